data_memory_responder: RTL and testbench

Word-addressed data-memory responder that serves load/store requests from the processor datapath's memory port. It accepts one request at a time through a request/acknowledge handshake and inserts a programmable number of wait states. It returns read data or commits write data on completion. It sits between the core's ALU-result/write-data outputs and its read-data input, and replaces an ideal zero-latency memory so that multi-cycle and stalling microarchitectures can be exercised.

---
 rtl/data_memory_responder_if.sv | 34 +++
 rtl/data_memory_responder.sv | 158 +++++++++++++++
 tb/tb_data_memory_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Memory-port bundle between the core datapath and the data memory.
// MemFault exists only when DMEM_ALIGN_CHECK_EN is defined.
interface data_memory_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemAck;
    logic        MemBusy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        MemFault;

    modport master (
        output MemReq, MemWrite, Addr, WriteData,
        input  ReadData, MemAck, MemBusy, MemFault
    );

    modport slave (
        input  MemReq, MemWrite, Addr, WriteData,
        output ReadData, MemAck, MemBusy, MemFault
    );
`else
    modport master (
        output MemReq, MemWrite, Addr, WriteData,
        input  ReadData, MemAck, MemBusy
    );

    modport slave (
        input  MemReq, MemWrite, Addr, WriteData,
        output ReadData, MemAck, MemBusy
    );
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN adds misaligned-access faulting.
module data_memory_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic                     clk,
    input  logic                     Reset,
    data_memory_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          mis_q, mis_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem_q [DEPTH];

    logic          commit;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;
    logic          c_write;
    logic          c_mis;
    logic          in_mis;
    logic          mem_we;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = |bus.Addr[1:0];
    logic unused_addr;
    assign unused_addr = ^bus.Addr[31:AW+2];
`else
    assign in_mis = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{bus.Addr[31:AW+2], bus.Addr[1:0]};
`endif

    // Sequencer: latch request, count wait states, pick commit source
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        mis_d   = mis_q;
        commit  = 1'b0;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_write = write_q;
        c_mis   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (bus.MemReq) begin
                    idx_d   = bus.Addr[AW+1:2];
                    wdata_d = bus.WriteData;
                    write_d = bus.MemWrite;
                    mis_d   = in_mis;
                    cnt_d   = WAIT_CNT;
                    // Zero wait states commit straight from the inputs
                    c_idx   = bus.Addr[AW+1:2];
                    c_wdata = bus.WriteData;
                    c_write = bus.MemWrite;
                    c_mis   = in_mis;
                    if (WAIT_CNT != 4'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Commit: store to array, load into ReadData, or fault
    always_comb begin
        rdata_d = rdata_q;
        fault_d = 1'b0;
        mem_we  = 1'b0;
        if (commit) begin
            if (c_mis) begin
                rdata_d = 32'd0;
                fault_d = 1'b1;
            end else if (c_write) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem_q[c_idx];
            end
        end
    end

    // Control and data registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Storage array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[c_idx] <= c_wdata;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.MemAck   = (state_q == S_ACK);
    assign bus.MemBusy  = (state_q != S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.MemFault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: WAIT=2 instance for latency/alias/reset tests,
// WAIT=0 instance for back-to-back held-request tests.
module tb_data_memory_responder;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    typedef logic [31:0] v3_t [3];

    logic clk;
    logic Reset;

    data_memory_responder_if if2 ();
    data_memory_responder_if if0 ();

    data_memory_responder #(.DEPTH(64), .WAIT(2)) u_dut2 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (if2)
    );

    data_memory_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (if0)
    );

    exp_t q2[$];
    exp_t q0[$];
    int total;
    int passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor for the WAIT=2 instance
    always @(negedge clk) begin
        if (if2.MemAck === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_ack", 32'(q2.size()), 32'd1);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_rdata", if2.ReadData, e.rd);
`ifdef DMEM_ALIGN_CHECK_EN
                chk("dut2_fault", 32'(if2.MemFault), 32'(e.flt));
`endif
            end
        end
    end

    // Monitor for the WAIT=0 instance
    always @(negedge clk) begin
        if (if0.MemAck === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_ack", 32'(q0.size()), 32'd1);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_rdata", if0.ReadData, e.rd);
            end
        end
    end

    // Single access on the WAIT=2 instance; chg mutates inputs
    // and drops MemReq right after acceptance
    task automatic acc(bit wr, logic [31:0] a, logic [31:0] d,
                       logic [31:0] rd, bit flt, bit chg);
        int lat;
        int busy;
        bit got;
        q2.push_back('{rd: rd, flt: flt});
        @(negedge clk);
        if2.MemReq    = 1'b1;
        if2.MemWrite  = wr;
        if2.Addr      = a;
        if2.WriteData = d;
        lat  = 0;
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (if2.MemBusy) busy++;
            if (chg && i == 0) begin
                if2.Addr      = a + 32'd4;
                if2.WriteData = ~d;
                if2.MemReq    = 1'b0;
            end
            if (if2.MemAck) begin
                got = 1'b1;
                if2.MemReq = 1'b0;
            end
        end
        chk("dut2_ack_seen", 32'(got), 32'd1);
        chk("dut2_latency", 32'(lat), 32'd3);
        chk("dut2_busy_cycles", 32'(busy), 32'd3);
        @(negedge clk);
        chk("dut2_ack_pulse", 32'(if2.MemAck), 32'd0);
    endtask

    // Three accesses on the WAIT=0 instance with MemReq held high
    task automatic b2b(bit wr, v3_t a, v3_t d, v3_t rd);
        int gap;
        bit got;
        q0.push_back('{rd: rd[0], flt: 1'b0});
        @(negedge clk);
        if0.MemReq    = 1'b1;
        if0.MemWrite  = wr;
        if0.Addr      = a[0];
        if0.WriteData = d[0];
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                gap++;
                if (if0.MemAck) got = 1'b1;
            end
            chk("dut0_ack_seen", 32'(got), 32'd1);
            chk("dut0_ack_spacing", 32'(gap), (k == 0) ? 32'd1 : 32'd2);
            if (k < 2) begin
                if0.Addr      = a[k+1];
                if0.WriteData = d[k+1];
                q0.push_back('{rd: rd[k+1], flt: 1'b0});
            end else begin
                if0.MemReq = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    v3_t ba;
    v3_t bd;
    v3_t bz;

    initial begin
        total  = 0;
        passed = 0;
        Reset  = 1'b0;
        if2.MemReq = 1'b0; if2.MemWrite = 1'b0;
        if2.Addr = 32'd0;  if2.WriteData = 32'd0;
        if0.MemReq = 1'b0; if0.MemWrite = 1'b0;
        if0.Addr = 32'd0;  if0.WriteData = 32'd0;
        #12;
        chk("reset_rdata", if2.ReadData, 32'd0);
        chk("reset_ack", 32'(if2.MemAck), 32'd0);
        chk("reset_busy", 32'(if2.MemBusy), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("reset_fault", 32'(if2.MemFault), 32'd0);
`endif
        @(negedge clk);
        Reset = 1'b1;

        // WAIT=0 back-to-back stores then loads
        ba = '{32'h0, 32'h4, 32'h8};
        bd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        bz = '{32'h0, 32'h0, 32'h0};
        b2b(1'b1, ba, bd, bz);
        b2b(1'b0, ba, bz, bd);

        // WAIT=2 store/load and aliasing
        acc(1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        acc(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        acc(1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
        acc(1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0, 1'b0);
        acc(1'b1, 32'h20,  32'h0BADF00D, 32'h12345678, 1'b0, 1'b0);

        // Reset during WAIT aborts a store
        @(negedge clk);
        if2.MemReq    = 1'b1;
        if2.MemWrite  = 1'b1;
        if2.Addr      = 32'h20;
        if2.WriteData = 32'hAAAA5555;
        @(negedge clk);
        chk("abort_busy_before", 32'(if2.MemBusy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("abort_ack", 32'(if2.MemAck), 32'd0);
        chk("abort_busy", 32'(if2.MemBusy), 32'd0);
        chk("abort_rdata", if2.ReadData, 32'd0);
        if2.MemReq = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        acc(1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

        // Input changes after acceptance are ignored
        acc(1'b1, 32'h34, 32'h34343434, 32'h0BADF00D, 1'b0, 1'b0);
        acc(1'b1, 32'h30, 32'h30303030, 32'h0BADF00D, 1'b0, 1'b1);
        acc(1'b0, 32'h30, 32'h0,        32'h30303030, 1'b0, 1'b0);
        acc(1'b0, 32'h34, 32'h0,        32'h34343434, 1'b0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        acc(1'b1, 32'h40, 32'h40404040, 32'h34343434, 1'b0, 1'b0);
        acc(1'b1, 32'h42, 32'h11111111, 32'h0,        1'b1, 1'b0);
        acc(1'b0, 32'h40, 32'h0,        32'h40404040, 1'b0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
